// File: rtl/lbm_fill_pkg.sv
// Shared types and default geometry for the LBM cell fill master.
// Grid is stored row-major, one DATA_W word per cell.
package lbm_fill_pkg;

    localparam int COORD_W_DEF = 27;
    localparam int GRID_W_DEF  = 320;
    localparam int GRID_H_DEF  = 240;
    localparam int ADDR_W_DEF  = 17;
    localparam int DATA_W_DEF  = 32;
    localparam int LEN_W_DEF   = 16;

    localparam int LAST_CELL = GRID_W_DEF * GRID_H_DEF - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lbm_cell_addr.sv
// Registers the row-major word address y*GRID_W+x and an out-of-grid flag
// when en_i is high; results are valid the cycle after, no backpressure.
module lbm_cell_addr
    import lbm_fill_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [ADDR_W-1:0]  base_o,
    output logic               oob_o
);

    localparam int PROD_W = 2 * COORD_W;

    logic [ADDR_W-1:0] base_d, base_q;
    logic              oob_d, oob_q;

    // Full-width product; truncation is only meaningful when oob is clear.
    always_comb begin
        base_d = ADDR_W'(PROD_W'(y_i) * PROD_W'(GRID_W) + PROD_W'(x_i));
        oob_d  = (x_i >= COORD_W'(GRID_W)) || (y_i >= COORD_W'(GRID_H));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q <= '0;
            oob_q  <= 1'b0;
        end else if (en_i) begin
            base_q <= base_d;
            oob_q  <= oob_d;
        end
    end

    assign base_o = base_q;
    assign oob_o  = oob_q;

endmodule

// File: rtl/lbm_cell_fill_master.sv
// Turns one toggle-handshake PIO command into a run of single-word Avalon writes.
// First write two cycles after command detect; m_waitrequest stalls the current beat.
module lbm_cell_fill_master
    import lbm_fill_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] x_coord,
    input  logic [COORD_W-1:0] y_coord,
    input  logic [DATA_W-1:0]  fill_data,
    input  logic [LEN_W-1:0]   run_len,
    input  logic               cmd_req,
    output logic               cmd_ack,
    output logic               busy,
    output logic               err,
    output logic [ADDR_W-1:0]  m_address,
    output logic               m_write,
    output logic [DATA_W-1:0]  m_writedata,
    input  logic               m_waitrequest
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(GRID_W * GRID_H - 1);

    state_t             state_q;
    logic               cmd_ack_q, busy_q, err_q, m_write_q;
    logic [ADDR_W-1:0]  m_address_q;
    logic [DATA_W-1:0]  m_writedata_q;
    logic [LEN_W-1:0]   remaining_q;
    logic               accept;
    logic [ADDR_W-1:0]  base;
    logic               oob;

    assign accept = (state_q == IDLE) && (cmd_req != cmd_ack_q);

    // Coordinates are captured by the address stage at the accept edge only.
    lbm_cell_addr #(
        .COORD_W (COORD_W),
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .ADDR_W  (ADDR_W)
    ) u_addr (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (accept),
        .x_i     (x_coord),
        .y_i     (y_coord),
        .base_o  (base),
        .oob_o   (oob)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cmd_ack_q     <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            remaining_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        m_writedata_q <= fill_data;
                        remaining_q   <= run_len;
                        err_q         <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= CALC;
                    end
                end
                CALC: begin
                    if (oob) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (remaining_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        m_address_q <= base;
                        m_write_q   <= 1'b1;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    if (!m_waitrequest) begin
                        if (remaining_q == LEN_W'(1)) begin
                            m_write_q <= 1'b0;
                            state_q   <= DONE;
                        end else if (m_address_q == LastAddr) begin
                            // Run would leave the grid: stop at the last cell.
                            err_q     <= 1'b1;
                            m_write_q <= 1'b0;
                            state_q   <= DONE;
                        end else begin
                            m_address_q <= m_address_q + ADDR_W'(1);
                            remaining_q <= remaining_q - LEN_W'(1);
                        end
                    end
                end
                DONE: begin
                    cmd_ack_q <= ~cmd_ack_q;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ack     = cmd_ack_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign m_write     = m_write_q;
    assign m_address   = m_address_q;
    assign m_writedata = m_writedata_q;

endmodule

// File: tb/tb_lbm_cell_fill_master.sv
// Scoreboarded bench for lbm_cell_fill_master: expected beats are queued at issue,
// a negedge monitor pops and compares every accepted Avalon write.
module tb_lbm_cell_fill_master;

    logic        clk;
    logic        reset_n;
    logic [26:0] x_coord, y_coord;
    logic [31:0] fill_data;
    logic [15:0] run_len;
    logic        cmd_req;
    logic        cmd_ack, busy, err;
    logic [16:0] m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int stall_at = 0;
    int stall_left = 0;

    logic [16:0] exp_addr[$];
    logic [31:0] exp_data[$];

    lbm_cell_fill_master dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .x_coord       (x_coord),
        .y_coord       (y_coord),
        .fill_data     (fill_data),
        .run_len       (run_len),
        .cmd_req       (cmd_req),
        .cmd_ack       (cmd_ack),
        .busy          (busy),
        .err           (err),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic issue(input int x, input int y, input logic [31:0] fill, input int len);
        x_coord   = 27'(x);
        y_coord   = 27'(y);
        fill_data = fill;
        run_len   = 16'(len);
        cmd_req   = ~cmd_req;
    endtask

    task automatic push_run(input int base, input int n, input logic [31:0] fill);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(17'(base + i));
            exp_data.push_back(fill);
        end
    endtask

    // Waits for the next cmd_ack toggle, counting edges from the call.
    task automatic wait_ack(input string name, input int exp_cycles, input logic exp_err,
                            input int exp_left);
        logic old;
        int   n;
        old = cmd_ack;
        n   = 0;
        while (cmd_ack == old && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (cmd_ack == old) begin
            chk({name, "_ack_timeout"}, 64'(n), 64'(exp_cycles));
        end else begin
            chk({name, "_cycles"}, 64'(n), 64'(exp_cycles));
            chk({name, "_err"}, 64'(err), 64'(exp_err));
            chk({name, "_busy"}, 64'(busy), 64'd0);
            chk({name, "_pending_beats"}, 64'(exp_addr.size()), 64'(exp_left));
        end
    endtask

    initial begin
        logic        prev_stall;
        logic [16:0] prev_addr;
        logic [31:0] prev_data;
        int          start, n;

        reset_n       = 1'b0;
        x_coord       = '0;
        y_coord       = '0;
        fill_data     = '0;
        run_len       = '0;
        cmd_req       = 1'b0;
        m_waitrequest = 1'b0;
        prev_stall    = 1'b0;
        prev_addr     = '0;
        prev_data     = '0;

        fork
            forever begin
                @(negedge clk);
                if (!reset_n) begin
                    prev_stall = 1'b0;
                end else begin
                    if (prev_stall) begin
                        chk("stall_write_held", 64'(m_write), 64'd1);
                        chk("stall_addr_held", 64'(m_address), 64'(prev_addr));
                        chk("stall_data_held", 64'(m_writedata), 64'(prev_data));
                    end
                    prev_stall = m_write && m_waitrequest;
                    prev_addr  = m_address;
                    prev_data  = m_writedata;
                    if (m_write && !m_waitrequest) begin
                        acc_cnt++;
                        if (exp_addr.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                                     m_address, m_writedata);
                        end else begin
                            chk("beat_addr", 64'(m_address), 64'(exp_addr.pop_front()));
                            chk("beat_data", 64'(m_writedata), 64'(exp_data.pop_front()));
                        end
                    end
                end
            end
            forever begin
                @(posedge clk);
                #1;
                if (m_write && stall_left > 0 && acc_cnt + 1 == stall_at) begin
                    m_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    m_waitrequest = 1'b0;
                end
            end
        join_none

        #3;
        chk("rst_cmd_ack", 64'(cmd_ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_m_write", 64'(m_write), 64'd0);
        chk("rst_m_address", 64'(m_address), 64'd0);
        chk("rst_m_writedata", 64'(m_writedata), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single cell: 2*320+5 = 645.
        issue(5, 2, 32'hA5A5_A5A5, 1);
        push_run(645, 1, 32'hA5A5_A5A5);
        wait_ack("single", 4, 1'b0, 0);

        // Row wrap with a 3-cycle stall on beat 2.
        start      = acc_cnt;
        stall_at   = acc_cnt + 2;
        stall_left = 3;
        issue(318, 0, 32'h1234_5678, 4);
        push_run(318, 4, 32'h1234_5678);
        wait_ack("wrap_stall", 10, 1'b0, 0);
        chk("wrap_stall_beats", 64'(acc_cnt - start), 64'd4);

        // Out-of-range x, then out-of-range y: no writes, error set.
        issue(320, 0, 32'hDEAD_BEEF, 3);
        wait_ack("x_oob", 3, 1'b1, 0);
        issue(0, 240, 32'hDEAD_BEEF, 1);
        wait_ack("y_oob", 3, 1'b1, 0);

        // Truncated at the grid end: 239*320+318 = 76798, then 76799.
        issue(318, 239, 32'h0BAD_F00D, 5);
        push_run(76798, 2, 32'h0BAD_F00D);
        wait_ack("grid_end", 5, 1'b1, 0);

        // Zero length clears the previous error.
        issue(7, 7, 32'h5555_5555, 0);
        wait_ack("len0", 3, 1'b0, 0);

        // Toggle during a run queues the next command right after DONE.
        issue(0, 0, 32'hCAFE_0001, 8);
        push_run(0, 8, 32'hCAFE_0001);
        repeat (3) @(posedge clk);
        #1;
        issue(0, 1, 32'hCAFE_0002, 2);
        push_run(320, 2, 32'hCAFE_0002);
        wait_ack("queued_first", 8, 1'b0, 2);
        @(posedge clk);
        #1;
        chk("queued_second_accepted", 64'(busy), 64'd1);
        wait_ack("queued_second", 4, 1'b0, 0);

        // Reset after 3 of 8 beats abandons the run.
        start = acc_cnt;
        issue(0, 10, 32'h7777_0000, 8);
        push_run(3200, 8, 32'h7777_0000);
        n = 0;
        while (acc_cnt < start + 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("midrun_three_beats", 64'(acc_cnt - start), 64'd3);
        reset_n = 1'b0;
        cmd_req = 1'b0;
        #1;
        chk("midrun_m_write", 64'(m_write), 64'd0);
        chk("midrun_m_address", 64'(m_address), 64'd0);
        chk("midrun_m_writedata", 64'(m_writedata), 64'd0);
        chk("midrun_busy", 64'(busy), 64'd0);
        chk("midrun_cmd_ack", 64'(cmd_ack), 64'd0);
        chk("midrun_err", 64'(err), 64'd0);
        chk("midrun_abandoned_beats", 64'(exp_addr.size()), 64'd5);
        exp_addr.delete();
        exp_data.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_m_write", 64'(m_write), 64'd0);
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_beats", 64'(acc_cnt - start), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
